memory_stage: RTL and testbench

- Pipeline stage directly downstream of execute.
- Registers the 7-bit control bundle, ALU result, store data, sequential PC and destination index from execute.
- Runs load/store accesses on a req/ack data-memory port and stalls upstream while an access is outstanding.
- Produces registered, aligned, sign/zero-extended writeback data for the writeback stage.

---
 rtl/memory_stage_pkg.sv | 31 +++
 rtl/memory_stage_mem_align.sv | 49 ++++
 rtl/memory_stage_reg.sv | 17 +
 rtl/memory_stage.sv | 133 +++++++++++++
 tb/tb_memory_stage.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_stage_pkg.sv
// Shared definitions for the memory stage: bundle bit positions, size and
// writeback-select codes, FSM state encoding.
package memory_stage_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned BUNDLE_W = 7;
  localparam int unsigned DEST_W   = 5;

  localparam int unsigned B_MEM_READ  = 6;
  localparam int unsigned B_MEM_WRITE = 5;
  localparam int unsigned B_SIZE_HI   = 4;
  localparam int unsigned B_SIZE_LO   = 3;
  localparam int unsigned B_UNSIGNED  = 2;
  localparam int unsigned B_WB_HI     = 1;
  localparam int unsigned B_WB_LO     = 0;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_PC   = 2'b10;
  localparam logic [1:0] WB_NONE = 2'b11;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/memory_stage_mem_align.sv
// Byte-lane steering for the data port: store replication and byte enables,
// misalignment detection, and load lane extraction with sign/zero extension.
module memory_stage_mem_align
  import memory_stage_pkg::*;
(
  input  logic [1:0]      size,
  input  logic [1:0]      addr_lo,
  input  logic            is_write,
  input  logic            load_unsigned,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be_c,
  output logic [XLEN-1:0] wdata_c,
  output logic            misalign_c,
  output logic [XLEN-1:0] load_data_c
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    be_c        = 4'hF;
    wdata_c     = store_data;
    misalign_c  = 1'b0;
    load_data_c = rdata;
    byte_lane   = rdata[{addr_lo, 3'b000} +: 8];
    half_lane   = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (size)
      SZ_BYTE: begin
        wdata_c     = {4{store_data[7:0]}};
        be_c        = 4'b0001 << addr_lo;
        load_data_c = load_unsigned ? {24'b0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      end
      SZ_HALF: begin
        wdata_c     = {2{store_data[15:0]}};
        be_c        = 4'b0011 << addr_lo;
        misalign_c  = addr_lo[0];
        load_data_c = load_unsigned ? {16'b0, half_lane} : {{16{half_lane[15]}}, half_lane};
      end
      SZ_WORD: misalign_c = (addr_lo != 2'b00);
      default: misalign_c = 1'b1;
    endcase

    // Reads always fetch the full word; lane selection happens on the way back.
    if (!is_write) be_c = 4'hF;
  end

endmodule

// File: rtl/memory_stage_reg.sv
// Generic enabled pipeline register with synchronous active-high clear.
module memory_stage_reg #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: registers execute results, runs req/ack data accesses
// and produces registered writeback. Define MEM_TIMEOUT_EN for the ack timeout.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [BUNDLE_W-1:0] bundle_in,
  input  logic [XLEN-1:0]     alu_in,
  input  logic [XLEN-1:0]     store_in,
  input  logic [XLEN-1:0]     pc_seq_in,
  input  logic [DEST_W-1:0]   dest_in,
  input  logic                valid_in,
  output logic                stall_out,
  output logic                mem_req_out,
  output logic                mem_we_out,
  output logic [XLEN-1:0]     mem_addr_out,
  output logic [XLEN-1:0]     mem_wdata_out,
  output logic [3:0]          mem_be_out,
  input  logic                mem_ack_in,
  input  logic [XLEN-1:0]     mem_rdata_in,
  output logic                wb_en_out,
  output logic [DEST_W-1:0]   wb_dest_out,
  output logic [XLEN-1:0]     wb_data_out,
  output logic                valid_out,
  output logic                misalign_out,
  output logic                bus_err_out
);

  localparam int unsigned PIPE_W = 1 + BUNDLE_W + 3 * XLEN + DEST_W;

  logic                r_valid;
  logic [BUNDLE_W-1:0] r_bundle;
  logic [XLEN-1:0]     r_alu, r_store, r_pc;
  logic [DEST_W-1:0]   r_dest;
  logic                load_en;

  state_t              state;
  logic                mem_op_c, misalign_c, align_mis_c, timeout_c, done_c;
  logic [XLEN-1:0]     load_data_c, wb_data_c;
  logic [1:0]          wb_sel;

  assign load_en = ~stall_out;

  memory_stage_reg #(.W(PIPE_W)) u_pipe (
    .clk   (clk),
    .reset (reset),
    .en    (load_en),
    .d     ({valid_in, bundle_in, alu_in, store_in, pc_seq_in, dest_in}),
    .q     ({r_valid, r_bundle, r_alu, r_store, r_pc, r_dest})
  );

  memory_stage_mem_align u_mem_align (
    .size          (r_bundle[B_SIZE_HI:B_SIZE_LO]),
    .addr_lo       (r_alu[1:0]),
    .is_write      (r_bundle[B_MEM_WRITE]),
    .load_unsigned (r_bundle[B_UNSIGNED]),
    .store_data    (r_store),
    .rdata         (mem_rdata_in),
    .be_c          (mem_be_out),
    .wdata_c       (mem_wdata_out),
    .misalign_c    (align_mis_c),
    .load_data_c   (load_data_c)
  );

  assign wb_sel       = r_bundle[B_WB_HI:B_WB_LO];
  assign mem_op_c     = r_valid & (r_bundle[B_MEM_READ] | r_bundle[B_MEM_WRITE]);
  assign misalign_c   = mem_op_c & align_mis_c;
  assign mem_we_out   = r_bundle[B_MEM_WRITE];
  assign mem_addr_out = {r_alu[XLEN-1:2], 2'b00};

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] wait_cnt;

  // Ack in the final wait cycle still wins over the timeout.
  assign timeout_c = (state == S_WAIT) && (wait_cnt == CNT_W'(TIMEOUT - 1)) && !mem_ack_in;

  always_ff @(posedge clk) begin
    if (reset || state == S_IDLE) wait_cnt <= '0;
    else                          wait_cnt <= wait_cnt + CNT_W'(1);
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_c      = 1'b0;
`endif

  // Request and stall are combinational so a zero-wait ack costs no cycle.
  assign mem_req_out = !reset && ((state == S_WAIT) ? !timeout_c : (mem_op_c && !align_mis_c));
  assign stall_out   = mem_req_out & ~mem_ack_in;
  assign done_c      = !reset && r_valid &&
                       (!mem_op_c || misalign_c || (mem_req_out && mem_ack_in) || timeout_c);

  always_comb begin
    wb_data_c = '0;
    case (wb_sel)
      WB_ALU:  wb_data_c = r_alu;
      WB_MEM:  wb_data_c = load_data_c;
      WB_PC:   wb_data_c = r_pc;
      default: wb_data_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      valid_out    <= 1'b0;
      wb_en_out    <= 1'b0;
      wb_dest_out  <= '0;
      wb_data_out  <= '0;
      misalign_out <= 1'b0;
      bus_err_out  <= 1'b0;
    end else begin
      case (state)
        S_IDLE:  if (mem_req_out && !mem_ack_in) state <= S_WAIT;
        S_WAIT:  if (mem_ack_in || timeout_c)    state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      valid_out    <= done_c;
      wb_en_out    <= done_c && (wb_sel != WB_NONE) && !misalign_c && !timeout_c;
      misalign_out <= done_c && misalign_c;
      bus_err_out  <= done_c && timeout_c;
      if (done_c) begin
        wb_dest_out <= r_dest;
        wb_data_out <= wb_data_c;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: vector table of single-cycle ops plus
// sequences for wait states, reset mid-access and the MEM_TIMEOUT_EN path.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  bundle_in;
  logic [31:0] alu_in, store_in, pc_seq_in;
  logic [4:0]  dest_in;
  logic        valid_in;
  logic        stall_out, mem_req_out, mem_we_out;
  logic [31:0] mem_addr_out, mem_wdata_out;
  logic [3:0]  mem_be_out;
  logic        mem_ack_in;
  logic [31:0] mem_rdata_in;
  logic        wb_en_out;
  logic [4:0]  wb_dest_out;
  logic [31:0] wb_data_out;
  logic        valid_out, misalign_out, bus_err_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  memory_stage #(.TIMEOUT(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .bundle_in     (bundle_in),
    .alu_in        (alu_in),
    .store_in      (store_in),
    .pc_seq_in     (pc_seq_in),
    .dest_in       (dest_in),
    .valid_in      (valid_in),
    .stall_out     (stall_out),
    .mem_req_out   (mem_req_out),
    .mem_we_out    (mem_we_out),
    .mem_addr_out  (mem_addr_out),
    .mem_wdata_out (mem_wdata_out),
    .mem_be_out    (mem_be_out),
    .mem_ack_in    (mem_ack_in),
    .mem_rdata_in  (mem_rdata_in),
    .wb_en_out     (wb_en_out),
    .wb_dest_out   (wb_dest_out),
    .wb_data_out   (wb_data_out),
    .valid_out     (valid_out),
    .misalign_out  (misalign_out),
    .bus_err_out   (bus_err_out)
  );

  typedef struct {
    string       name;
    logic [6:0]  bundle;
    logic [31:0] alu, store, pc;
    logic [4:0]  dest;
    logic        ack;
    logic [31:0] rdata;
    logic        exp_req, exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_en;
    logic [31:0] exp_data;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic void add(input string name, input logic [6:0] b, input logic [31:0] a,
                              input logic [31:0] s, input logic [31:0] p, input logic [4:0] d,
                              input logic ack, input logic [31:0] rd, input logic req,
                              input logic we, input logic [3:0] be, input logic [31:0] wd,
                              input logic en, input logic [31:0] data, input logic mis);
    vec_t v;
    v.name = name; v.bundle = b; v.alu = a; v.store = s; v.pc = p; v.dest = d;
    v.ack = ack; v.rdata = rd; v.exp_req = req; v.exp_we = we; v.exp_be = be;
    v.exp_wdata = wd; v.exp_en = en; v.exp_data = data; v.exp_mis = mis;
    vecs.push_back(v);
  endfunction

  // Present one op for a single edge, then return 1 time unit into its cycle.
  task automatic issue(input logic [6:0] b, input logic [31:0] a, input logic [31:0] s,
                       input logic [31:0] p, input logic [4:0] d);
    @(negedge clk);
    bundle_in = b; alu_in = a; store_in = s; pc_seq_in = p; dest_in = d; valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    mem_ack_in = 1'b0;
  endtask

  initial begin
    int stalled;
    reset = 1'b1; bundle_in = '0; alu_in = '0; store_in = '0; pc_seq_in = '0;
    dest_in = '0; valid_in = 1'b0; mem_ack_in = 1'b0; mem_rdata_in = '0;

    //   name        bundle      alu           store         pc            dst ack rdata         req we be       wdata         en data          mis
    add("lw",        7'b1010001, 32'h00000100, 32'h0,        32'h00001000, 5'd1, 1, 32'hDEADBEEF, 1, 0, 4'b1111, 32'h0,        1, 32'hDEADBEEF, 0);
    add("lb_s",      7'b1000001, 32'h00000103, 32'h0,        32'h00001004, 5'd2, 1, 32'h80FFFFFF, 1, 0, 4'b1111, 32'h0,        1, 32'hFFFFFF80, 0);
    add("lb_u",      7'b1000101, 32'h00000103, 32'h0,        32'h00001008, 5'd3, 1, 32'h80FFFFFF, 1, 0, 4'b1111, 32'h0,        1, 32'h00000080, 0);
    add("lh_s",      7'b1001001, 32'h00000102, 32'h0,        32'h0000100C, 5'd4, 1, 32'h80011234, 1, 0, 4'b1111, 32'h0,        1, 32'hFFFF8001, 0);
    add("lh_u",      7'b1001101, 32'h00000100, 32'h0,        32'h00001010, 5'd5, 1, 32'h8001F234, 1, 0, 4'b1111, 32'h0,        1, 32'h0000F234, 0);
    add("lbu_lane1", 7'b1000101, 32'h00000101, 32'h0,        32'h00001014, 5'd6, 1, 32'h11223344, 1, 0, 4'b1111, 32'h0,        1, 32'h00000033, 0);
    add("sh",        7'b0101011, 32'h00000102, 32'h1234ABCD, 32'h00001018, 5'd7, 1, 32'h0,        1, 1, 4'b1100, 32'hABCDABCD, 0, 32'h0,        0);
    add("sb",        7'b0100011, 32'h00000101, 32'h000000A5, 32'h0000101C, 5'd8, 1, 32'h0,        1, 1, 4'b0010, 32'hA5A5A5A5, 0, 32'h0,        0);
    add("sw",        7'b0110011, 32'h00000200, 32'hCAFEF00D, 32'h00001020, 5'd9, 1, 32'h0,        1, 1, 4'b1111, 32'hCAFEF00D, 0, 32'h0,        0);
    add("rw_both",   7'b1110011, 32'h00000300, 32'h0BADCAFE, 32'h00001024, 5'd10, 1, 32'h0,       1, 1, 4'b1111, 32'h0BADCAFE, 0, 32'h0,        0);
    add("lw_mis",    7'b1010001, 32'h00000101, 32'h0,        32'h00001028, 5'd11, 0, 32'h0,       0, 0, 4'b0,    32'h0,        0, 32'h0,        1);
    add("lh_mis",    7'b1001001, 32'h00000103, 32'h0,        32'h0000102C, 5'd12, 0, 32'h0,       0, 0, 4'b0,    32'h0,        0, 32'h0,        1);
    add("sz11_mis",  7'b1011001, 32'h00000100, 32'h0,        32'h00001030, 5'd13, 0, 32'h0,       0, 0, 4'b0,    32'h0,        0, 32'h0,        1);
    add("sw_mis",    7'b0110011, 32'h00000102, 32'h11111111, 32'h00001034, 5'd14, 0, 32'h0,       0, 0, 4'b0,    32'h0,        0, 32'h0,        1);
    add("alu_op",    7'b0000000, 32'h12345678, 32'h0,        32'h00001038, 5'd15, 0, 32'h0,       0, 0, 4'b0,    32'h0,        1, 32'h12345678, 0);
    add("pc_op",     7'b0000010, 32'h00000055, 32'h0,        32'h00000404, 5'd16, 0, 32'h0,       0, 0, 4'b0,    32'h0,        1, 32'h00000404, 0);
    add("none_op",   7'b0000011, 32'h00000077, 32'h0,        32'h00001040, 5'd17, 0, 32'h0,       0, 0, 4'b0,    32'h0,        0, 32'h0,        0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_wb_en", 32'(wb_en_out), 32'd0);
    check("rst_dest", 32'(wb_dest_out), 32'd0);
    check("rst_data", wb_data_out, 32'd0);
    check("rst_mis", 32'(misalign_out), 32'd0);
    check("rst_berr", 32'(bus_err_out), 32'd0);
    check("rst_req", 32'(mem_req_out), 32'd0);
    check("rst_stall", 32'(stall_out), 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      issue(vecs[i].bundle, vecs[i].alu, vecs[i].store, vecs[i].pc, vecs[i].dest);
      mem_ack_in = vecs[i].ack;
      mem_rdata_in = vecs[i].rdata;
      #1;
      check({vecs[i].name, ".req"}, 32'(mem_req_out), 32'(vecs[i].exp_req));
      check({vecs[i].name, ".stall"}, 32'(stall_out), 32'd0);
      if (vecs[i].exp_req) begin
        check({vecs[i].name, ".addr"}, mem_addr_out, vecs[i].alu & 32'hFFFFFFFC);
        check({vecs[i].name, ".we"}, 32'(mem_we_out), 32'(vecs[i].exp_we));
        check({vecs[i].name, ".be"}, 32'(mem_be_out), 32'(vecs[i].exp_be));
        if (vecs[i].exp_we) check({vecs[i].name, ".wdata"}, mem_wdata_out, vecs[i].exp_wdata);
      end
      @(posedge clk);
      #1;
      mem_ack_in = 1'b0;
      check({vecs[i].name, ".valid"}, 32'(valid_out), 32'd1);
      check({vecs[i].name, ".wb_en"}, 32'(wb_en_out), 32'(vecs[i].exp_en));
      check({vecs[i].name, ".dest"}, 32'(wb_dest_out), 32'(vecs[i].dest));
      check({vecs[i].name, ".mis"}, 32'(misalign_out), 32'(vecs[i].exp_mis));
      check({vecs[i].name, ".berr"}, 32'(bus_err_out), 32'd0);
      if (vecs[i].exp_en) check({vecs[i].name, ".data"}, wb_data_out, vecs[i].exp_data);
      @(posedge clk);
      #1;
      check({vecs[i].name, ".valid_drop"}, 32'(valid_out), 32'd0);
    end

    // Signed byte load, ack after 3 stalled cycles; upstream inputs change meanwhile
    issue(7'b1000001, 32'h00000103, 32'h0, 32'h0, 5'd20);
    alu_in = 32'hFFFFFFFF;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("dly.stall%0d", c), 32'(stall_out), 32'd1);
      check($sformatf("dly.addr%0d", c), mem_addr_out, 32'h00000100);
      check($sformatf("dly.valid%0d", c), 32'(valid_out), 32'd0);
      @(posedge clk);
      #1;
    end
    mem_ack_in = 1'b1;
    mem_rdata_in = 32'h80FFFFFF;
    #1;
    check("dly.stall_rel", 32'(stall_out), 32'd0);
    @(posedge clk);
    #1;
    mem_ack_in = 1'b0;
    check("dly.valid", 32'(valid_out), 32'd1);
    check("dly.data", wb_data_out, 32'hFFFFFF80);
    check("dly.dest", 32'(wb_dest_out), 32'd20);

    // Reset while waiting, then a late ack
    issue(7'b1010001, 32'h00000100, 32'h0, 32'h0, 5'd21);
    @(posedge clk);
    #1;
    check("rma.req_wait", 32'(mem_req_out), 32'd1);
    reset = 1'b1;
    #1;
    check("rma.req_drop", 32'(mem_req_out), 32'd0);
    check("rma.stall_drop", 32'(stall_out), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    mem_ack_in = 1'b1;
    mem_rdata_in = 32'h12345678;
    check("rma.valid_rst", 32'(valid_out), 32'd0);
    #1;
    check("rma.late_req", 32'(mem_req_out), 32'd0);
    check("rma.late_stall", 32'(stall_out), 32'd0);
    @(posedge clk);
    #1;
    mem_ack_in = 1'b0;
    check("rma.no_retire", 32'(valid_out), 32'd0);
    check("rma.no_wb", 32'(wb_en_out), 32'd0);

`ifdef MEM_TIMEOUT_EN
    // Ack never arrives: request held for 4 stalled cycles, then bus error
    issue(7'b1010001, 32'h00000100, 32'h0, 32'h0, 5'd22);
    stalled = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (stall_out !== 1'b1) break;
      stalled++;
      @(posedge clk);
      #1;
    end
    check("to.stall_cycles", 32'(stalled), 32'd4);
    check("to.req_drop", 32'(mem_req_out), 32'd0);
    @(posedge clk);
    #1;
    check("to.valid", 32'(valid_out), 32'd1);
    check("to.berr", 32'(bus_err_out), 32'd1);
    check("to.wb_en", 32'(wb_en_out), 32'd0);
    check("to.mis", 32'(misalign_out), 32'd0);
`else
    // Without the timeout the wait persists well past TIMEOUT cycles
    issue(7'b1010001, 32'h00000100, 32'h0, 32'h0, 5'd22);
    stalled = 0;
    for (int c = 0; c < 70; c++) begin
      #1;
      if (stall_out === 1'b1) stalled++;
      @(posedge clk);
      #1;
    end
    check("nto.stall_cycles", 32'(stalled), 32'd70);
    mem_ack_in = 1'b1;
    mem_rdata_in = 32'h0000BEEF;
    @(posedge clk);
    #1;
    mem_ack_in = 1'b0;
    check("nto.valid", 32'(valid_out), 32'd1);
    check("nto.berr", 32'(bus_err_out), 32'd0);
    check("nto.data", wb_data_out, 32'h0000BEEF);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
